// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stall/flush generation,
// memory-wait watchdog FSM and saturating performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_branch_taken,
  input  logic             i_imem_ready,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_id_ex_stall,
  output logic             o_ex_mem_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_flush,
  output logic [1:0]       o_state,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_lu_cnt
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t             state_q;
  state_t             wait_kind_s;
  logic [WAIT_W-1:0]  wait_q;
  logic [WAIT_W-1:0]  wait_run_s;
  logic               fault_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic               dwait_s, iwait_s, lu_s, frozen_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && !(&v)) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  assign frozen_s = (state_q == ST_FAULT);
  assign dwait_s  = i_dmem_req & ~i_dmem_ready;
  assign iwait_s  = ~i_imem_ready;
  assign lu_s     = i_ex_is_load & i_ex_rd_wr & (i_ex_rd_addr != 5'd0) &
                    ((i_id_rs1_used & (i_ex_rd_addr == i_id_rs1_addr)) |
                     (i_id_rs2_used & (i_ex_rd_addr == i_id_rs2_addr)));

  // Prioritised stall/flush selection; exactly one hazard case drives the pipeline.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;
    if (frozen_s) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
    end else if (dwait_s) begin
      // A taken branch waits in EX until the data access completes.
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
      o_mem_wb_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
    end else if (lu_s) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_flush  = 1'b1;
    end else if (iwait_s) begin
      o_pc_stall     = 1'b1;
      o_if_id_flush  = 1'b1;
    end else begin
      o_pc_stall     = 1'b0;
    end
  end

  // Wait type requested this cycle and the resulting consecutive-cycle count.
  always_comb begin
    if (dwait_s) begin
      wait_kind_s = ST_DMEM_WAIT;
    end else if (iwait_s && !i_ex_branch_taken) begin
      wait_kind_s = ST_IMEM_WAIT;
    end else begin
      wait_kind_s = ST_RUN;
    end
    if (wait_kind_s == state_q) begin
      wait_run_s = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_run_s = {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  // Watchdog FSM: tracks consecutive memory-wait cycles, FAULT is left only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FAULT: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
        default: begin
          if (wait_kind_s == ST_RUN) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
          end else if (wait_run_s == WAIT_W'(TIMEOUT)) begin
            state_q <= ST_FAULT;
            wait_q  <= wait_run_s;
            fault_q <= 1'b1;
          end else begin
            state_q <= wait_kind_s;
            wait_q  <= wait_run_s;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, ~frozen_s & o_pc_stall);
    flush_cnt_d = sat_inc(flush_cnt_q, ~frozen_s & ~dwait_s & i_ex_branch_taken);
    lu_cnt_d    = sat_inc(lu_cnt_q, ~frozen_s & ~dwait_s & ~i_ex_branch_taken & lu_s);
  end

  // Performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_fault     = fault_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_lu_cnt    = lu_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: reset-time vector table, directed corner
// sequences and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, wr, ld, br, irdy, dreq, drdy;
  logic pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, mwb_fl, fault;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt, lu_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_state, m_wait, m_fault, m_stall, m_flush, m_lu;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .WAIT_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2),
    .i_ex_rd_addr(rd), .i_ex_rd_wr(wr), .i_ex_is_load(ld),
    .i_ex_branch_taken(br), .i_imem_ready(irdy),
    .i_dmem_req(dreq), .i_dmem_ready(drdy),
    .o_pc_stall(pc_st), .o_if_id_stall(ifid_st), .o_id_ex_stall(idex_st),
    .o_ex_mem_stall(exmem_st), .o_if_id_flush(ifid_fl), .o_id_ex_flush(idex_fl),
    .o_mem_wb_flush(mwb_fl), .o_state(state), .o_fault(fault),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_lu_cnt(lu_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic wr, ld, br, irdy, dreq, drdy;
    logic [6:0] exp;  // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, mem_wb flush}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; rd = v.rd;
    wr = v.wr; ld = v.ld; br = v.br; irdy = v.irdy; dreq = v.dreq; drdy = v.drdy;
  endtask

  task automatic idle();
    vec_t v;
    v = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0};
    set_in(v);
  endtask

  function automatic logic [6:0] ctl_now();
    bit dw, iw, hz;
    dw = dreq && !drdy;
    iw = !irdy;
    hz = ld && wr && rd != 5'd0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (m_state == 3) return 7'b1111000;
    if (dw)           return 7'b1111001;
    if (br)           return 7'b0000110;
    if (hz)           return 7'b1100010;
    if (iw)           return 7'b1000100;
    return 7'b0000000;
  endfunction

  function automatic logic [6:0] ctl_dut();
    return {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, mwb_fl};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_fault = 0; m_stall = 0; m_flush = 0; m_lu = 0;
  endtask

  task automatic model_advance();
    logic [6:0] c;
    int kind, run;
    c = ctl_now();
    if (m_state != 3) begin
      if (c[6] && m_stall < CMAX) m_stall++;
      if (c == 7'b0000110 && m_flush < CMAX) m_flush++;
      if (c == 7'b1100010 && m_lu < CMAX) m_lu++;
      kind = (dreq && !drdy) ? 1 : ((!irdy && !br) ? 2 : 0);
      if (kind == 0) begin
        m_state = 0; m_wait = 0;
      end else begin
        run = (kind == m_state) ? m_wait + 1 : 1;
        if (run >= TO) begin
          m_state = 3; m_fault = 1;
        end else begin
          m_state = kind; m_wait = run;
        end
      end
    end
  endtask

  // Called at a falling edge with inputs applied; checks, then moves to the next falling edge.
  task automatic step();
    #1;
    chk("ctl", 32'(ctl_dut()), 32'(ctl_now()));
    chk("state", 32'(state), 32'(m_state));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("lu_cnt", 32'(lu_cnt), 32'(m_lu));
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'({fault, stall_cnt, flush_cnt, lu_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100010};
    tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[3]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[4]  = '{5'd7, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100010};
    tbl[5]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[6]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[8]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1111001};
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000};
    tbl[10] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000110};
    tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000100};
    tbl[12] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100010};

    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Vector table applied while reset holds the FSM in RUN.
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), 32'(ctl_dut()), 32'(tbl[i].exp));
    end
    @(negedge clk);
    idle();
    do_reset();

    // Load-use on rs2: one bubble, then clear.
    rs2 = 5'd5; u2 = 1'b1; rd = 5'd5; wr = 1'b1; ld = 1'b1;
    step();
    ld = 1'b0; wr = 1'b0; rd = 5'd0;
    #1;
    chk("lu_after", 32'(ctl_dut()), 32'd0);
    chk("lu_cnt_one", 32'(lu_cnt), 32'd1);
    step();

    // rd = x0 and unused rs1 must not stall.
    do_reset();
    idle();
    rs2 = 5'd0; u2 = 1'b1; rd = 5'd0; wr = 1'b1; ld = 1'b1;
    step();
    rs1 = 5'd9; u1 = 1'b0; u2 = 1'b0; rd = 5'd9;
    step();
    chk("lu_cnt_zero", 32'(lu_cnt), 32'd0);

    // Data wait with a pending branch, then branch resolves.
    do_reset();
    idle();
    dreq = 1'b1; drdy = 1'b0; br = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("dwait_state", 32'(state), 32'd1);
    drdy = 1'b1;
    #1;
    chk("branch_after_wait", 32'(ctl_dut()), 32'b0000110);
    step();
    idle();
    chk("dwait_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("dwait_stall_cnt", 32'(stall_cnt), 32'd3);
    step();

    // Branch beats load-use and fetch wait.
    do_reset();
    idle();
    br = 1'b1; irdy = 1'b0; rs1 = 5'd4; u1 = 1'b1; rd = 5'd4; wr = 1'b1; ld = 1'b1;
    step();
    chk("br_lu_cnt", 32'(lu_cnt), 32'd0);
    chk("br_state", 32'(state), 32'd0);

    // Watchdog: data never ready.
    do_reset();
    idle();
    dreq = 1'b1; drdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("wd_state", 32'(state), 32'd3);
    chk("wd_fault", 32'(fault), 32'd1);
    idle();
    step();
    step();
    chk("wd_stall_cnt", 32'(stall_cnt), 32'd4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_cnt", 32'({fault, stall_cnt, flush_cnt, lu_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Flush counter saturation.
    idle();
    br = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("flush_sat", 32'(flush_cnt), 32'd15);

    // Randomized traffic against the model.
    idle();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      ld   = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 4) == 0);
      irdy = ($urandom_range(0, 3) != 0);
      dreq = ($urandom_range(0, 2) == 0);
      drdy = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
